// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: valid/ready flow-control wrapper around a fixed-latency,
// always-accepting pipelined FIR. A tag pipe tracks which FIR slots carry real
// samples, and credits (in-flight + queued) keep the output FIFO from overflowing.
// Define FIR_CTRL_FLUSH_EN to build the FLUSH state, which pushes TAPS zeros
// through the FIR delay line on request. Without it, only RUN exists.
module fir_stream_ctrl #(
    parameter int unsigned DW         = 16,
    parameter int unsigned OW         = 32,
    parameter int unsigned TAPS       = 100,
    parameter int unsigned LATENCY    = 9,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [OW-1:0] m_data,
    output logic          fir_en,
    output logic [DW-1:0] fir_din,
    input  logic [OW-1:0] fir_dout,
    input  logic          flush,
    output logic          busy,
    output logic          flush_done,
    output logic          ovf
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Two spare bits so in-flight + queued can never wrap.
    localparam int unsigned CW = AW + 2;

    logic [LATENCY-1:0] tag_q, tag_d;
    logic [CW-1:0]      inflight_q, count_q, used;
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]      mem_q [FIFO_DEPTH];
    logic               ovf_q;
    logic               issue, tag_exit, pop, push_ok, full, empty, in_flush;

    assign used     = inflight_q + count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign tag_exit = tag_q[LATENCY-1];
    assign pop      = !empty && m_ready;
    // A push into a full FIFO is only harmless if a pop frees the slot this edge.
    assign push_ok  = tag_exit && (!full || pop);

`ifdef FIR_CTRL_FLUSH_EN
    localparam int unsigned FCW = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e         state_q;
    logic [FCW-1:0] flush_cnt_q;
    logic           flush_done_q;

    assign in_flush   = (state_q == StFlush);
    assign busy       = in_flush;
    assign flush_done = flush_done_q;

    // RUN/FLUSH sequencer; FLUSH lasts exactly TAPS cycles of zero injection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            flush_cnt_q  <= '0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (flush) begin
                        state_q     <= StFlush;
                        flush_cnt_q <= '0;
                    end
                end
                StFlush: begin
                    if (flush_cnt_q == FCW'(TAPS - 1)) begin
                        state_q      <= StRun;
                        flush_done_q <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end
`else
    logic        unused_flush;
    logic [31:0] unused_taps;

    assign unused_flush = flush;
    assign unused_taps  = 32'(TAPS);
    assign in_flush     = 1'b0;
    assign busy         = 1'b0;
    assign flush_done   = 1'b0;
`endif

    // Source handshake and FIR drive; ready is held low through reset
    always_comb begin
        s_ready = !rst && !in_flush && (used < CW'(FIFO_DEPTH));
        issue   = s_valid && s_ready;
        fir_en  = in_flush || issue;
        fir_din = in_flush ? '0 : s_data;
    end

    // Tag pipe: a 1 marks a FIR slot holding a real sample
    always_comb begin
        tag_d    = tag_q << 1;
        tag_d[0] = issue;
    end

    // Tag pipe register; shifts every cycle whether or not the FIR advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    // In-flight credit counter: up on issue, down when the tag leaves the pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
        end else if (issue && !tag_exit) begin
            inflight_q <= inflight_q + 1'b1;
        end else if (!issue && tag_exit) begin
            inflight_q <= inflight_q - 1'b1;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
            if (tag_exit && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= fir_dout;
        end
    end

    // First-word-fall-through output; data forced to 0 while empty
    always_comb begin
        m_valid = !empty;
        m_data  = empty ? '0 : mem_q[rd_ptr_q];
        ovf     = ovf_q;
    end

endmodule
